// File: rtl/serial_addsub_digit_if.sv
// Digit-serial add/sub stream interface: operand digits in, result digits out.
// master drives operands and observes results; slave is the datapath side.
interface serial_addsub_digit_if #(
  parameter int DIGIT_W = 4
);
  logic               in_valid;
  logic               in_first;
  logic               in_sub;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               out_valid;
  logic [DIGIT_W-1:0] sum;
  logic               out_last;
  logic               carry_out;
  logic               ovf;

  modport master (
    output in_valid, in_first, in_sub, a, b,
    input  out_valid, sum, out_last, carry_out, ovf
  );

  modport slave (
    input  in_valid, in_first, in_sub, a, b,
    output out_valid, sum, out_last, carry_out, ovf
  );
endinterface

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, least-significant digit first, DIGIT_W bits
// per cycle, WORD_DIGITS digits per word, carry held between digits.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables the signed overflow
// flag; without it ovf is tied low and the MSB carry-in tap is not built.
module serial_addsub_digit #(
  parameter int DIGIT_W     = 4,
  parameter int WORD_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_digit_if.slave  bus
);

  localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic               r_carry;
  logic               r_subMode;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  logic               w_accept;
  logic               w_subEff;
  logic               w_cin;
  logic               w_isLast;
  logic [DIGIT_W-1:0] w_bEff;
  logic [DIGIT_W-1:0] w_sum;
  logic [DIGIT_W:0]   w_carry;
  logic               w_ovf;

  // A digit counts only if it starts a word or continues one in progress;
  // digit 0 takes its mode and carry-in straight from in_sub.
  assign w_accept = bus.in_valid & (bus.in_first | r_busy);
  assign w_subEff = bus.in_first ? bus.in_sub : r_subMode;
  assign w_cin    = bus.in_first ? bus.in_sub : r_carry;
  assign w_bEff   = bus.b ^ {DIGIT_W{w_subEff}};
  assign w_isLast = bus.in_first ? (WORD_DIGITS == 1) : (r_cnt == LAST_CNT);

  // Ripple-carry chain of full adders built from plain gates.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = w_cin;
    for (int i = 0; i < DIGIT_W; i++) begin
      w_sum[i]       = bus.a[i] ^ w_bEff[i] ^ w_carry[i];
      w_carry[i + 1] = (bus.a[i] & w_bEff[i]) | (w_carry[i] & (bus.a[i] ^ w_bEff[i]));
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  assign w_ovf = w_carry[DIGIT_W-1] ^ w_carry[DIGIT_W];
`else
  assign w_ovf = 1'b0;
`endif

  // Registered outputs and word-tracking state; idle cycles clear the outputs
  // but leave carry/count/mode untouched so a word can stall indefinitely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry       <= 1'b0;
      r_subMode     <= 1'b0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.out_last  <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= w_accept;
      bus.sum       <= w_accept ? w_sum : '0;
      bus.out_last  <= w_accept & w_isLast;
      bus.carry_out <= w_accept & w_isLast & w_carry[DIGIT_W];
      bus.ovf       <= w_accept & w_isLast & w_ovf;
      if (w_accept) begin
        if (bus.in_first) begin
          r_subMode <= bus.in_sub;
        end
        if (w_isLast) begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_carry <= 1'b0;
        end else begin
          r_busy  <= 1'b1;
          r_cnt   <= bus.in_first ? ONE_CNT : r_cnt + ONE_CNT;
          r_carry <= w_carry[DIGIT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Self-checking bench for serial_addsub_digit (DIGIT_W=4, WORD_DIGITS=2).
// Reference model accumulates whole operands and uses plain word arithmetic.
module tb_serial_addsub_digit;

  localparam int DW = 4;
  localparam int WD = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_addsub_digit_if #(.DIGIT_W(DW)) bus ();

  serial_addsub_digit #(.DIGIT_W(DW), .WORD_DIGITS(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  bit              mBusy;
  int              mCnt;
  bit              mSub;
  longint unsigned mA;
  longint unsigned mB;

  logic          expValid;
  logic [DW-1:0] expSum;
  logic          expLast;
  logic          expCarry;
  logic          expOvf;

  task automatic checkOne(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".valid"}, DW'(bus.out_valid), DW'(expValid));
    checkOne({tag, ".sum"},   bus.sum,            expSum);
    checkOne({tag, ".last"},  DW'(bus.out_last),  DW'(expLast));
    checkOne({tag, ".carry"}, DW'(bus.carry_out), DW'(expCarry));
    checkOne({tag, ".ovf"},   DW'(bus.ovf),       DW'(expOvf));
  endtask

  task automatic modelStep(input bit v, input bit f, input bit s,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit              acc;
    int              idx;
    int              w;
    longint unsigned mask;
    longint unsigned bEff;
    longint unsigned total;
    bit              sA, sB, sR;
    acc      = v && (f || mBusy);
    expValid = acc;
    expSum   = '0;
    expLast  = 1'b0;
    expCarry = 1'b0;
    expOvf   = 1'b0;
    if (acc) begin
      if (f) begin
        mA   = 0;
        mB   = 0;
        mSub = s;
        idx  = 0;
      end else begin
        idx = mCnt;
      end
      mA    = mA | (64'(a) << (DW * idx));
      mB    = mB | (64'(b) << (DW * idx));
      w     = DW * (idx + 1);
      mask  = (64'd1 << w) - 64'd1;
      bEff  = mSub ? (~mB & mask) : mB;
      total = mA + bEff + 64'(mSub);
      expSum = DW'(total >> (DW * idx));
      if (idx == WD - 1) begin
        expLast  = 1'b1;
        expCarry = 1'((total >> w) & 64'd1);
        sA = 1'((mA >> (w - 1)) & 64'd1);
        sB = 1'((bEff >> (w - 1)) & 64'd1);
        sR = 1'((total >> (w - 1)) & 64'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        expOvf = (sA == sB) && (sR != sA);
`else
        expOvf = 1'b0;
`endif
        mBusy = 1'b0;
        mCnt  = 0;
      end else begin
        mBusy = 1'b1;
        mCnt  = idx + 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit f, input bit s,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input string tag);
    rst          = 1'b0;
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_sub   = s;
    bus.a        = a;
    bus.b        = b;
    modelStep(v, f, s, a, b);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset with a valid first digit present, so reset priority is exercised.
  task automatic applyReset(input string tag);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_sub   = 1'($urandom_range(0, 1));
    bus.a        = DW'($urandom);
    bus.b        = DW'($urandom);
    mBusy    = 1'b0;
    mCnt     = 0;
    mSub     = 1'b0;
    expValid = 1'b0;
    expSum   = '0;
    expLast  = 1'b0;
    expCarry = 1'b0;
    expOvf   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(tag);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic with occasional resets.
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_sub   = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    mA = 0;
    mB = 0;
    applyReset("reset");

    applyStimulus(1, 1, 0, 4'hC, 4'hB, "add.d0");
    applyStimulus(1, 0, 0, 4'h3, 4'h4, "add.d1");

    applyStimulus(1, 1, 1, 4'h0, 4'h1, "sub.d0");
    applyStimulus(1, 0, 0, 4'h1, 4'h0, "sub.d1");

    applyStimulus(1, 1, 0, 4'hF, 4'h1, "stall.d0");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 4'h5, 4'h5, "stall.gap");
    applyStimulus(1, 0, 0, 4'hF, 4'h0, "stall.d1");

    applyStimulus(1, 1, 0, 4'h1, 4'h2, "restart.old");
    applyStimulus(1, 1, 0, 4'h5, 4'h3, "restart.d0");
    applyStimulus(1, 0, 0, 4'h0, 4'h0, "restart.d1");

    applyStimulus(1, 1, 0, 4'h7, 4'h2, "rstmid.d0");
    applyReset("rstmid.rst");
    applyStimulus(1, 0, 0, 4'h3, 4'h3, "rstmid.drop");

    applyStimulus(1, 1, 0, 4'hF, 4'h1, "b2b.w0d0");
    applyStimulus(1, 0, 0, 4'h0, 4'h0, "b2b.w0d1");
    applyStimulus(1, 1, 1, 4'h0, 4'h1, "b2b.w1d0");
    applyStimulus(1, 0, 0, 4'h0, 4'h0, "b2b.w1d1");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        applyReset("rand.rst");
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_digit.md
# serial_addsub_digit

Digit-serial adder/subtractor: adds or subtracts two multi-digit operands streamed least-significant digit first, DIGIT_W bits per cycle, with a carry register carried between digits. It generalises the 1-bit serial adder to configurable digit width and word length. It adds a subtract mode, word framing, valid-based stalling and end-of-word carry/overflow flags. It sits between serialising front-ends and downstream digit-serial datapaths in the sequential-basics block set.

## Interface
- DIGIT_W, 4, bits processed per cycle (≥1)
- WORD_DIGITS, 8, digits per word (≥1); word width = DIGIT_W*WORD_DIGITS
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  a/b/in_first/in_sub valid this cycle
- in_first  input  1  current digit is digit 0 of a new word
- in_sub  input  1  operation select (0 add, 1 a−b); sampled only with in_valid & in_first
- a  input  DIGIT_W  operand A digit
- b  input  DIGIT_W  operand B digit
- out_valid  output  1  result digit valid
- sum  output  DIGIT_W  result digit
- out_last  output  1  result digit is the last (most significant) of the word
- carry_out  output  1  final carry (add: unsigned overflow; sub: 1 = no borrow), valid only with out_last
- ovf  output  1  signed two's-complement overflow, valid only with out_last

## Operation
- Digit adder: DIGIT_W-bit ripple-carry chain of full adders, each built from ^, &, |, ~ only. No `+` operator.
- Effective B: b when sub mode is 0, ~b when sub mode is 1.
- Carry-in to digit 0: the sampled in_sub value (1 for subtract). Carry-in to later digits: the carry register.
- State:
  - carry register (1 bit)
  - sub_mode register (latched at digit 0)
  - digit counter cnt, 0..WORD_DIGITS−1
  - busy flag (word in progress)
- Accepted digit: in_valid=1 and (in_first=1 or busy=1).
  - Digits arriving with in_valid=1, in_first=0, busy=0 are dropped. No output is produced for them.
- in_first=1 on an accepted digit:
  - cnt←1 (or busy←0 if WORD_DIGITS=1)
  - sub_mode←in_sub, carry←digit carry-out, busy←1
  - This holds even mid-word: the old word is abandoned and produces no out_last.
- Accepted non-first digit: carry←digit carry-out, cnt←cnt+1.
- When cnt = WORD_DIGITS−1 the digit is the last one:
  - out_last←1, carry_out←MSB carry-out
  - ovf←(carry into MSB) ^ (carry out of MSB)
  - busy←0, cnt←0, carry←0
- in_valid=0: all state holds (stall). Any number of idle cycles is allowed between digits.
- Counter wrap: cnt never exceeds WORD_DIGITS−1. It resets to 0 on the last digit.

## Timing
- All outputs are registered. Latency is 1 cycle from an accepted digit to out_valid=1 with its sum.
- For a non-accepted cycle, out_valid=0 next cycle. sum, out_last, carry_out and ovf also go to 0 (no stale data).
- Throughput: one digit per cycle, no bubbles between back-to-back words.
- Reset values: out_valid=0, sum=0, out_last=0, carry_out=0, ovf=0. Internal reset: carry=0, cnt=0, busy=0, sub_mode=0.
- Reset mid-word: the word is discarded and the next cycle's outputs are at reset values. A new word requires in_first.
- rst has priority over in_valid in the same cycle.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf computed as above.
- Not defined: ovf tied to 0 and the MSB carry-in tap is removed. All other behaviour is identical.

## Test plan
All scenarios use DIGIT_W=4, WORD_DIGITS=2.
- Add 0x3C+0x4B: digits (C,B,first),(3,4) → sum 7, then 8 with out_last=1, carry_out=0, ovf=1 (macro on) / 0 (macro off).
- Sub 0x10−0x01: digits (0,1,first,sub),(1,0) → sum F, then 0 with out_last=1, carry_out=1, ovf=0.
- Stall: add 0xFF+0x01 with 3 in_valid=0 cycles between the digits → sums 0, 0. carry_out=1. out_valid stays low during the gap.
- Restart: first digit of 0x11+0x22, then in_first again with 0x05+0x03 → sums 3, then 8, 0 with out_last only on the second word's digit 1.
- Reset mid-word: rst after digit 0 → outputs 0 next cycle. A following non-first digit is dropped (out_valid=0).
- Back-to-back: two words on consecutive cycles (0x0F+0x01, sub 0x00−0x01) → 0,1 (carry_out 0), then F,F (carry_out 0, borrow).
